// File: rtl/teclado_pkg.sv
// Shared types and helpers for the keypad controller: FSM states, widths and
// the one-hot key decoder.
package teclado_pkg;

  localparam int DIG_W  = 4;
  localparam int N_KEYS = 10;

  typedef enum logic [1:0] {IDLE, DEB, HOLD, REL} st_t;

  typedef struct packed {
    logic             vld;
    logic [DIG_W-1:0] dig;
  } dig_t;

  // vld is set only when exactly one key line is high
  function automatic dig_t onehot_to_dig(input logic [N_KEYS-1:0] v);
    dig_t r;
    int   n;
    r = '0;
    n = 0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (v[i]) begin
        r.dig = DIG_W'(i);
        n++;
      end
    end
    r.vld = (n == 1);
    return r;
  endfunction

endpackage

// File: rtl/fifo_dig.sv
// Show-ahead digit FIFO; head is visible on dout without a read strobe.
module fifo_dig
  import teclado_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [DIG_W-1:0] din,
  output logic [DIG_W-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [DIG_W-1:0] mem_q [DEPTH];
  logic [DIG_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pop_ok, push_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // a full FIFO still takes a push when the head leaves in the same cycle
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/teclado_ctrl.sv
// Keypad sequencer: registers raw key lines, debounces press/release, accepts
// one digit per press and queues it in the digit FIFO.
module teclado_ctrl
  import teclado_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_KEYS-1:0]          t,
  input  logic                       rd_en,
  input  logic                       clr,
  output logic [DIG_W-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       key_vld,
  output logic                       key_err,
  output logic                       pressed,
  output logic                       ovf
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES-1);

  st_t               st_q, st_d;
  logic [N_KEYS-1:0] t_q, cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              key_vld_q, key_vld_d, key_err_q, key_err_d, ovf_q, ovf_d;
  logic              acc;
  dig_t              dec;

  assign dec = onehot_to_dig(cand_q);

  always_comb begin
    st_d      = st_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    key_vld_d = 1'b0;
    key_err_d = 1'b0;
    acc       = 1'b0;
    case (st_q)
      IDLE: if (t_q != '0) begin
        st_d   = DEB;
        cand_d = t_q;
        cnt_d  = CNT_W'(1);
      end
      DEB: begin
        if (t_q != cand_q)     st_d  = IDLE;
        else if (cnt_q != LAST) cnt_d = cnt_q + CNT_W'(1);
        else begin
          st_d = HOLD;
          if (dec.vld) begin
            acc       = 1'b1;
            key_vld_d = 1'b1;
          end else begin
            key_err_d = 1'b1;
          end
        end
      end
      // other key changes while held are ignored until a full release
      HOLD: if (t_q == '0) begin
        st_d  = REL;
        cnt_d = CNT_W'(1);
      end
      REL: begin
        if (t_q != '0)         st_d  = HOLD;
        else if (cnt_q == LAST) st_d  = IDLE;
        else                    cnt_d = cnt_q + CNT_W'(1);
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (clr)                                    ovf_d = 1'b0;
    else if (acc && full && !(rd_en && !empty)) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      t_q       <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      key_vld_q <= 1'b0;
      key_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      t_q       <= t;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      key_vld_q <= key_vld_d;
      key_err_q <= key_err_d;
      ovf_q     <= ovf_d;
    end
  end

  fifo_dig #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (acc),
    .pop   (rd_en),
    .clr   (clr),
    .din   (dec.dig),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign key_vld = key_vld_q;
  assign key_err = key_err_q;
  assign pressed = (st_q == HOLD) || (st_q == REL);
  assign ovf     = ovf_q;

endmodule

// File: doc/teclado_ctrl.md
Name: teclado_ctrl

Overview:
Sequencing controller for the 10-key one-hot keypad. It registers the raw key lines, debounces press and release, and accepts exactly one digit per physical press. Multi-key chords are rejected. Accepted digits are queued in a small show-ahead FIFO that a downstream consumer drains with a read strobe. It sits between the raw keypad pins and any digit-consuming logic, such as PIN entry or display.

Parameters:
DEB_CYCLES, 4, consecutive identical samples required to accept a press or a release (legal range >= 2)
DEPTH, 4, digit FIFO depth (power of 2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, synchronous, active-low
t  in  10  raw key lines; bit i high = key i pressed
rd_en  in  1  pop request for the FIFO head
clr  in  1  synchronous flush of the FIFO and ovf; does not affect the debounce FSM
dout  out  4  FIFO head digit (0..9), valid when empty=0; reads 0 when empty
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  $clog2(DEPTH+1)  number of stored digits
key_vld  out  1  1-cycle pulse: digit accepted and pushed
key_err  out  1  1-cycle pulse: stable non-one-hot pattern rejected
pressed  out  1  high while FSM is in HOLD or REL
ovf  out  1  sticky: a press was accepted while FIFO was full

Behaviour:
- One clock; reset is synchronous and active-low. rst_n=0 at an edge forces FSM=IDLE, t_q=0, cnt=0, FIFO empty, and all outputs to 0 (empty=1). This holds mid-debounce and mid-hold.
- t is registered once into t_q. The FSM sees only t_q.
- Digit encoding: one-hot bit i maps to digit i (t=10'b0000001000 gives 3).
- FSM states: IDLE, DEB, HOLD, REL. Counter cnt is sized to DEB_CYCLES.
  - IDLE: t_q!=0 -> DEB, cand:=t_q, cnt:=1.
  - DEB, t_q!=cand (including 0): -> IDLE. This is bounce; nothing is pushed.
  - DEB, t_q==cand, cnt<DEB_CYCLES-1: cnt:=cnt+1.
  - DEB, t_q==cand, cnt==DEB_CYCLES-1, cand one-hot: push digit, key_vld:=1, -> HOLD.
  - DEB, t_q==cand, cnt==DEB_CYCLES-1, cand not one-hot: key_err:=1, no push, -> HOLD.
  - HOLD: t_q==0 -> REL, cnt:=1. Any nonzero change is ignored, so there is no second accept without a full release.
  - REL: t_q!=0 -> HOLD.
  - REL: t_q==0 and cnt==DEB_CYCLES-1 -> IDLE; otherwise cnt:=cnt+1.
- Latency: t stable before edge 0 (captured into t_q). key_vld is high and count is incremented in the cycle after edge DEB_CYCLES. key_vld and key_err are registered.
- FIFO (show-ahead):
  - dout = mem[rd_ptr] combinationally.
  - Pop occurs when rd_en=1 and empty=0. rd_en while empty is a no-op.
  - Push occurs on accept when not full.
  - Accept while full and no pop: digit is dropped, ovf:=1, key_vld still pulses.
  - Accept while full with a simultaneous pop: both occur, count unchanged, ovf unchanged.
  - Accept while empty with rd_en=1: push only.
  - Pointers wrap modulo DEPTH.
- clr=1: rd_ptr=wr_ptr=0, count=0, ovf:=0. clr has priority over a same-cycle push or pop; a push in that cycle is discarded.
- ovf clears only on reset or clr.

Decomposition:
- Package teclado_pkg holds:
  - st_t enum {IDLE, DEB, HOLD, REL}
  - DIG_W=4
  - N_KEYS=10
  - function onehot_to_dig (returns digit, plus a valid flag for exactly one bit set)
- Sub-module fifo_dig: parameterized DEPTH×DIG_W show-ahead FIFO with push, pop, clr, full, empty, count.
- The FSM and debounce counter live in teclado_ctrl.

Test Plan:
- Clean press: t=10'h008 held 10 cycles, then 0 -> key_vld once, 4 edges after capture; dout=3, count=1, pressed drops DEB_CYCLES edges after release.
- Bounce: t toggles 0x004/0x000 every 2 cycles for 12 cycles, then holds 0x004 -> exactly one key_vld, dout=2; no push during toggling.
- Chord: t=10'h003 stable 6 cycles -> key_err pulse, count stays 0. Changing t to 0x001 while still held -> no accept until full release.
- Overflow: 5 presses of keys 1,2,3,4,5 with no reads -> full=1, ovf=1, reads yield 1,2,3,4. Then clr -> ovf=0, empty=1.
- Simultaneous: FIFO full, accept of key 9 in the same cycle as rd_en=1 -> count stays 4, ovf=0, last read returns 9.
- Reset mid-operation: rst_n=0 during DEB with cnt=2 and FIFO holding 2 digits -> next cycle IDLE, empty=1, all outputs 0. A held key is re-debounced from cnt=1 after release of reset.
